// File: rtl/settle_chain_sched_if.sv
// Handshake/result bundle for settle_chain_sched: master drives start/c,
// slave returns status and settled chain values.
interface settle_chain_sched_if #(
  parameter int WIDTH    = 1,
  parameter int MAX_ITER = 8
);
  localparam int CNT_W = $clog2(MAX_ITER + 1);

  logic             start;
  logic [WIDTH-1:0] c;
  logic             busy;
  logic             done;
  logic             nonconv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CNT_W-1:0] iter_count;
  logic [CNT_W-1:0] max_iter_seen;

  // start is a request with no ready: it is accepted only on an IDLE edge and
  // ignored otherwise; done is a one-cycle pulse, and nonconv/a/b/iter_count
  // are valid with it and held until the next accepted start.
  modport master (
    output start, c,
    input  busy, done, nonconv, a, b, iter_count, max_iter_seen
  );

  modport slave (
    input  start, c,
    output busy, done, nonconv, a, b, iter_count, max_iter_seen
  );
endinterface

// File: rtl/settle_chain_sched.sv
// Settle-loop sequencer for an N-stage assign chain (c -> ... -> b -> a).
// Optional high-water iteration tracking is built when SETTLE_STATS_EN is defined.
module settle_chain_sched #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 2,
  parameter int MAX_ITER = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  settle_chain_sched_if.slave  bus,
  output logic [1:0]           o_dbg_state
);
  localparam int CNT_W = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVAL = 2'd1, S_RESP = 2'd2} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_c_q;
  logic [WIDTH-1:0] r_stage [DEPTH];
  logic             r_busy;
  logic             r_done;
  logic             r_nonconv;
  logic [CNT_W-1:0] r_iter;
  logic [CNT_W-1:0] w_max_seen;
  logic             w_changed;
  logic             w_shift;

  always_comb begin
    w_changed = (r_c_q != r_stage[0]);
    for (int i = 1; i < DEPTH; i++) begin
      w_changed = w_changed | (r_stage[i] != r_stage[i-1]);
    end
  end

  assign w_shift = w_changed && (r_iter < MAX_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_c_q     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_nonconv <= 1'b0;
      r_iter    <= '0;
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_c_q     <= bus.c;
            r_iter    <= '0;
            r_nonconv <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (w_shift) begin
            r_stage[0] <= r_c_q;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            r_iter <= r_iter + 1'b1;
          end else begin
            // Still changing here means the iteration budget ran out.
            r_nonconv <= w_changed;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SETTLE_STATS_EN
  logic [CNT_W-1:0] r_max_seen;

  // Updated on the edge that enters RESP, when r_iter is final for the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_seen <= '0;
    end else if (r_state == S_EVAL && !w_shift && r_iter > r_max_seen) begin
      r_max_seen <= r_iter;
    end
  end

  assign w_max_seen = r_max_seen;
`else
  assign w_max_seen = '0;
`endif

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.nonconv       = r_nonconv;
  assign bus.a             = r_stage[DEPTH-1];
  assign bus.b             = r_stage[DEPTH-2];
  assign bus.iter_count    = r_iter;
  assign bus.max_iter_seen = w_max_seen;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_settle_chain_sched.sv
// Directed + random bench for settle_chain_sched: a 2-stage 1-bit chain and a
// 4-stage 4-bit chain whose iteration limit is below its depth.
module tb_settle_chain_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg0, dbg1;

  always #5 clk = ~clk;

  settle_chain_sched_if #(.WIDTH(1), .MAX_ITER(8)) if0 ();
  settle_chain_sched_if #(.WIDTH(4), .MAX_ITER(3)) if1 ();

  settle_chain_sched #(.WIDTH(1), .DEPTH(2), .MAX_ITER(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .o_dbg_state(dbg0));
  settle_chain_sched #(.WIDTH(4), .DEPTH(4), .MAX_ITER(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .o_dbg_state(dbg1));

  int n_checks = 0;
  int n_err    = 0;
  int m_st [2][8];
  int exp_max [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chain settles once every stage holds c; after k shifts stages [0..k-1]
  // hold c and the rest are the old values moved down by k, so the shifts
  // needed are DEPTH minus the run of leading stages already equal to c.
  function automatic void model(input int id, input int depth, input int maxi,
                                input int cv, output int it, output int nc);
    int lead = 0;
    int k;
    while (lead < depth && m_st[id][lead] == cv) lead++;
    k  = depth - lead;
    nc = (k > maxi) ? 1 : 0;
    it = (k > maxi) ? maxi : k;
    for (int i = depth - 1; i >= 0; i--)
      m_st[id][i] = (i < it) ? cv : m_st[id][i - it];
`ifdef SETTLE_STATS_EN
    if (it > exp_max[id]) exp_max[id] = it;
`endif
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < 2; j++) begin
      exp_max[j] = 0;
      for (int i = 0; i < 8; i++) m_st[j][i] = 0;
    end
  endfunction

  function automatic logic get_done(input int id);
    return (id == 0) ? if0.done : if1.done;
  endfunction

  task automatic run(input int id, input int cv);
    int it, nc, lat, depth, maxi;
    depth = (id == 0) ? 2 : 4;
    maxi  = (id == 0) ? 8 : 3;
    @(negedge clk);
    if (id == 0) begin if0.start = 1'b1; if0.c = 1'(cv); end
    else         begin if1.start = 1'b1; if1.c = 4'(cv); end
    model(id, depth, maxi, cv, it, nc);
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    chk($sformatf("busy_eval%0d", id), (id == 0) ? if0.busy : if1.busy, 1);
    lat = 0;
    while (!get_done(id) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("done_latency%0d", id), lat, it + 1);
    if (id == 0) begin
      chk("iter0", if0.iter_count, it);
      chk("nonconv0", if0.nonconv, nc);
      chk("a0", if0.a, m_st[0][1]);
      chk("b0", if0.b, m_st[0][0]);
      chk("busy_resp0", if0.busy, 0);
      chk("max0", if0.max_iter_seen, exp_max[0]);
    end else begin
      chk("iter1", if1.iter_count, it);
      chk("nonconv1", if1.nonconv, nc);
      chk("a1", if1.a, m_st[1][3]);
      chk("b1", if1.b, m_st[1][2]);
      chk("busy_resp1", if1.busy, 0);
      chk("max1", if1.max_iter_seen, exp_max[1]);
    end
  endtask

  initial begin
    int cnt, accepts, pulses, it, nc, cv;
    rst_n = 1'b0;
    if0.start = 1'b0; if0.c = '0;
    if1.start = 1'b0; if1.c = '0;
    model_reset();

    #12;
    chk("rst_a0", if0.a, 0);
    chk("rst_b0", if0.b, 0);
    chk("rst_busy0", if0.busy, 0);
    chk("rst_done0", if0.done, 0);
    chk("rst_nonconv0", if0.nonconv, 0);
    chk("rst_iter0", if0.iter_count, 0);
    chk("rst_max0", if0.max_iter_seen, 0);
    chk("rst_a1", if1.a, 0);
    chk("rst_iter1", if1.iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full ripple, immediate re-settle, then opposite values.
    run(0, 1);
    run(0, 1);
    run(0, 0);
    run(0, 0);
    run(0, 1);

    // Deeper chain with a short budget: mixes convergence and limit hits.
    for (int n = 0; n < 25; n++) run(1, $urandom_range(0, 3));

    // start held high with c toggling: one accept per IDLE visit.
    @(negedge clk);
    @(negedge clk);
    cnt = 0; accepts = 0; pulses = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (if0.done) pulses++;
      if0.start = 1'b1;
      if0.c = 1'(cyc % 2 == 0 ? (m_st[0][0] == 0 ? 1 : 0) : cyc / 2 % 2);
      cv = int'(if0.c);
      @(posedge clk);
      if (cnt == 0) begin
        model(0, 2, 8, cv, it, nc);
        accepts++;
        cnt = it + 2;
      end else begin
        cnt--;
      end
      @(negedge clk);
    end
    if0.start = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (if0.done) pulses++;
      @(negedge clk);
    end
    chk("held_start_pulses", pulses, accepts);
    chk("held_start_a", if0.a, m_st[0][1]);
    chk("held_start_b", if0.b, m_st[0][0]);
    chk("held_start_max", if0.max_iter_seen, exp_max[0]);

    // Asynchronous reset in the middle of a two-shift run.
    @(negedge clk);
    if0.start = 1'b1;
    if0.c = (m_st[0][0] == 0) ? 1'b1 : 1'b0;
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_a0", if0.a, 0);
    chk("arst_b0", if0.b, 0);
    chk("arst_busy0", if0.busy, 0);
    chk("arst_done0", if0.done, 0);
    chk("arst_iter0", if0.iter_count, 0);
    chk("arst_max0", if0.max_iter_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (if0.done) pulses++;
      @(negedge clk);
    end
    chk("arst_no_done", pulses, 0);
    run(0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
